// File: rtl/term_tile_pkg.sv
// term_tile_pkg: shared types and mode-frame layout for the fabric edge
// termination tile (term_tile_cfg_loopback and term_loop_pipe).
//
// Mode frame layout (FrameData bits captured on the CFG strobe):
//   [1:0] group 1, [3:2] 2MID, [5:4] 2END, [7:6] group 4, [9:8] NN4,
//   [11:10] loopback pipeline depth, [12] hold.
package term_tile_pkg;

  typedef enum logic [1:0] {
    TM_ZERO  = 2'b00,
    TM_PASS  = 2'b01,
    TM_ROT   = 2'b10,
    TM_CONST = 2'b11
  } term_mode_e;

  localparam int unsigned CFG_W     = 13;
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned DEPTH_W   = 2;

  localparam int unsigned OFS_G1    = 0;
  localparam int unsigned OFS_G2MID = 2;
  localparam int unsigned OFS_G2END = 4;
  localparam int unsigned OFS_G4    = 6;
  localparam int unsigned OFS_GNN4  = 8;
  localparam int unsigned OFS_DEPTH = 10;
  localparam int unsigned OFS_HOLD  = 12;

  // Constant-pattern slices, taken from the low 16 bits of the pattern frame.
  localparam int unsigned PAT_W         = 16;
  localparam int unsigned PAT_OFS_G1    = 0;
  localparam int unsigned PAT_OFS_G2MID = 4;
  localparam int unsigned PAT_OFS_G2END = 8;
  localparam int unsigned PAT_OFS_G4    = 0;

  // Field order mirrors the frame so the packed struct equals raw bits [12:0].
  typedef struct packed {
    logic                hold;
    logic [DEPTH_W-1:0]  depth;
    term_mode_e          nn4;
    term_mode_e          g4;
    term_mode_e          g2end;
    term_mode_e          g2mid;
    term_mode_e          g1;
  } term_cfg_t;

  function automatic term_cfg_t unpack_cfg(input logic [CFG_W-1:0] raw);
    term_cfg_t c;
    c.g1    = term_mode_e'(raw[OFS_G1    +: MODE_W]);
    c.g2mid = term_mode_e'(raw[OFS_G2MID +: MODE_W]);
    c.g2end = term_mode_e'(raw[OFS_G2END +: MODE_W]);
    c.g4    = term_mode_e'(raw[OFS_G4    +: MODE_W]);
    c.nn4   = term_mode_e'(raw[OFS_GNN4  +: MODE_W]);
    c.depth = raw[OFS_DEPTH +: DEPTH_W];
    c.hold  = raw[OFS_HOLD];
    return c;
  endfunction

  function automatic logic [DEPTH_W-1:0] clamp_depth(input logic [DEPTH_W-1:0] d,
                                                     input int unsigned max_d);
    return (32'(d) > max_d) ? DEPTH_W'(max_d) : d;
  endfunction

endpackage

// File: rtl/term_loop_pipe.sv
// term_loop_pipe: variable-depth delay line for one loopback wire group.
//
// Ports:
//   clk    in  1         clock, rising edge
//   rst    in  1         synchronous reset, active-high (stages to 0)
//   clear  in  1         zero all stages this cycle (depth change)
//   hold   in  1         freeze all stages; output becomes static
//   depth  in  2         delay in cycles, already clamped to PIPE_MAX
//   d_in   in  W         mode-mux output
//   d_out  out W         d_in delayed by depth cycles
module term_loop_pipe
  import term_tile_pkg::*;
#(
  parameter int unsigned W        = 4,
  parameter int unsigned PIPE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               hold,
  input  logic [DEPTH_W-1:0] depth,
  input  logic [W-1:0]       d_in,
  output logic [W-1:0]       d_out
);

  // At least one stage exists so depth 0 can still freeze under hold.
  localparam int unsigned NS = (PIPE_MAX < 1) ? 1 : PIPE_MAX;

  logic [W-1:0] stg [NS];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int unsigned i = 0; i < NS; i++) begin
        stg[i] <= '0;
      end
    end else if (!hold) begin
      stg[0] <= d_in;
      for (int unsigned i = 1; i < NS; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  // Depth 0 is combinational, except under hold where stage 0 (the last
  // mux value registered before hold took effect) is presented instead.
  always_comb begin
    d_out = hold ? stg[0] : d_in;
    for (int unsigned i = 1; i <= NS; i++) begin
      if (32'(depth) == i) begin
        d_out = stg[i-1];
      end
    end
  end

endmodule

// File: rtl/term_tile_cfg_loopback.sv
// term_tile_cfg_loopback: configurable fabric edge termination tile.
// Loops incoming END wires back as BEG wires with a per-group mode
// (zero / pass / rotate / constant) and a 0..PIPE_MAX stage registered
// loopback pipeline. Configuration is frame-loaded into shadow registers
// and copied to the active set on the rising edge of the commit strobe.
//
// Ports:
//   UserCLK        in  1                clock
//   RST            in  1                synchronous reset, active-high
//   UserCLKo       out 1                forwarded clock
//   FrameData      in  FrameBitsPerRow  configuration frame data
//   FrameData_O    out FrameBitsPerRow  forwarded frame data (or readback)
//   FrameStrobe    in  MaxFramesPerCol  frame strobes
//   FrameStrobe_O  out MaxFramesPerCol  forwarded strobes
//   N1END/N2MID/N2END/N4END/NN4END  in   incoming wires
//   S1BEG/S2BEG/S2BEGb/S4BEG/SS4BEG out  looped-back wires
//   cfg_active     out 1                set once a commit has happened
//
// Build option: TERM_CFG_READBACK_EN -- while FrameStrobe[COMMIT_FRAME] is
// high, FrameData_O carries the zero-padded active configuration.
module term_tile_cfg_loopback
  import term_tile_pkg::*;
#(
  parameter int unsigned W1              = 4,
  parameter int unsigned W2              = 8,
  parameter int unsigned W4              = 16,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned CFG_FRAME       = 0,
  parameter int unsigned PAT_FRAME       = 1,
  parameter int unsigned COMMIT_FRAME    = 2,
  parameter int unsigned PIPE_MAX        = 3
) (
  input  logic                       UserCLK,
  input  logic                       RST,
  output logic                       UserCLKo,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  output logic [FrameBitsPerRow-1:0] FrameData_O,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
  input  logic [W1-1:0]              N1END,
  input  logic [W2-1:0]              N2MID,
  input  logic [W2-1:0]              N2END,
  input  logic [W4-1:0]              N4END,
  input  logic [W4-1:0]              NN4END,
  output logic [W1-1:0]              S1BEG,
  output logic [W2-1:0]              S2BEG,
  output logic [W2-1:0]              S2BEGb,
  output logic [W4-1:0]              S4BEG,
  output logic [W4-1:0]              SS4BEG,
  output logic                       cfg_active
);

  logic [MaxFramesPerCol-1:0] strobe_q;
  logic [MaxFramesPerCol-1:0] strobe_ev;
  logic                       ev_cfg;
  logic                       ev_pat;
  logic                       ev_commit;

  logic [CFG_W-1:0]           shadow_cfg;
  logic [FrameBitsPerRow-1:0] shadow_pat;
  term_cfg_t                  active_cfg;
  logic [PAT_W-1:0]           active_pat;
  logic                       cfg_active_q;

  logic [DEPTH_W-1:0]         shadow_depth;
  logic [DEPTH_W-1:0]         active_depth;
  logic                       pipe_clear;

  logic [W1-1:0] k1;
  logic [W2-1:0] k2mid;
  logic [W2-1:0] k2end;
  logic [W4-1:0] k4;
  logic [W1-1:0] mux1;
  logic [W2-1:0] mux2mid;
  logic [W2-1:0] mux2end;
  logic [W4-1:0] mux4;
  logic [W4-1:0] muxnn4;

  // ---------------------------------------------------------------- strobes
  assign strobe_ev = FrameStrobe & ~strobe_q;
  assign ev_cfg    = strobe_ev[CFG_FRAME];
  assign ev_pat    = strobe_ev[PAT_FRAME];
  assign ev_commit = strobe_ev[COMMIT_FRAME];

  // Commit reads the shadow value from before this edge, so a capture in
  // the same cycle only lands in shadow.
  always_ff @(posedge UserCLK) begin
    if (RST) begin
      strobe_q     <= '0;
      shadow_cfg   <= '0;
      shadow_pat   <= '0;
      active_cfg   <= '0;
      active_pat   <= '0;
      cfg_active_q <= 1'b0;
    end else begin
      strobe_q <= FrameStrobe;
      if (ev_cfg) begin
        shadow_cfg <= FrameData[CFG_W-1:0];
      end
      if (ev_pat) begin
        shadow_pat <= FrameData;
      end
      if (ev_commit) begin
        active_cfg   <= unpack_cfg(shadow_cfg);
        active_pat   <= shadow_pat[PAT_W-1:0];
        cfg_active_q <= 1'b1;
      end
    end
  end

  assign cfg_active = cfg_active_q;

  // ------------------------------------------------------------- pipe depth
  assign shadow_depth = clamp_depth(shadow_cfg[OFS_DEPTH +: DEPTH_W], PIPE_MAX);
  assign active_depth = clamp_depth(active_cfg.depth, PIPE_MAX);
  assign pipe_clear   = ev_commit && (shadow_depth != active_depth);

  // -------------------------------------------------------------- mode muxes
  function automatic logic [W1-1:0] mux_w1(input term_mode_e m,
                                           input logic [W1-1:0] n,
                                           input logic [W1-1:0] k);
    logic [W1-1:0] r;
    r = '0;
    case (m)
      TM_PASS:  r = n;
      TM_ROT:   for (int unsigned i = 0; i < W1; i++) r[i] = n[(i + 1) % W1];
      TM_CONST: r = k;
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [W2-1:0] mux_w2(input term_mode_e m,
                                           input logic [W2-1:0] n,
                                           input logic [W2-1:0] k);
    logic [W2-1:0] r;
    r = '0;
    case (m)
      TM_PASS:  r = n;
      TM_ROT:   for (int unsigned i = 0; i < W2; i++) r[i] = n[(i + 1) % W2];
      TM_CONST: r = k;
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [W4-1:0] mux_w4(input term_mode_e m,
                                           input logic [W4-1:0] n,
                                           input logic [W4-1:0] k);
    logic [W4-1:0] r;
    r = '0;
    case (m)
      TM_PASS:  r = n;
      TM_ROT:   for (int unsigned i = 0; i < W4; i++) r[i] = n[(i + 1) % W4];
      TM_CONST: r = k;
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Constant slices: wider groups zero-extend, narrower ones truncate.
  assign k1    = W1'(active_pat >> PAT_OFS_G1);
  assign k2mid = W2'(active_pat >> PAT_OFS_G2MID);
  assign k2end = W2'(active_pat >> PAT_OFS_G2END);
  assign k4    = W4'(active_pat >> PAT_OFS_G4);

  assign mux1    = mux_w1(active_cfg.g1,    N1END,  k1);
  assign mux2mid = mux_w2(active_cfg.g2mid, N2MID,  k2mid);
  assign mux2end = mux_w2(active_cfg.g2end, N2END,  k2end);
  assign mux4    = mux_w4(active_cfg.g4,    N4END,  k4);
  assign muxnn4  = mux_w4(active_cfg.nn4,   NN4END, k4);

  // ---------------------------------------------------------- loop pipes
  term_loop_pipe #(.W(W1), .PIPE_MAX(PIPE_MAX)) u_pipe_1 (
    .clk(UserCLK), .rst(RST), .clear(pipe_clear), .hold(active_cfg.hold),
    .depth(active_depth), .d_in(mux1), .d_out(S1BEG)
  );

  term_loop_pipe #(.W(W2), .PIPE_MAX(PIPE_MAX)) u_pipe_2mid (
    .clk(UserCLK), .rst(RST), .clear(pipe_clear), .hold(active_cfg.hold),
    .depth(active_depth), .d_in(mux2mid), .d_out(S2BEG)
  );

  term_loop_pipe #(.W(W2), .PIPE_MAX(PIPE_MAX)) u_pipe_2end (
    .clk(UserCLK), .rst(RST), .clear(pipe_clear), .hold(active_cfg.hold),
    .depth(active_depth), .d_in(mux2end), .d_out(S2BEGb)
  );

  term_loop_pipe #(.W(W4), .PIPE_MAX(PIPE_MAX)) u_pipe_4 (
    .clk(UserCLK), .rst(RST), .clear(pipe_clear), .hold(active_cfg.hold),
    .depth(active_depth), .d_in(mux4), .d_out(S4BEG)
  );

  term_loop_pipe #(.W(W4), .PIPE_MAX(PIPE_MAX)) u_pipe_nn4 (
    .clk(UserCLK), .rst(RST), .clear(pipe_clear), .hold(active_cfg.hold),
    .depth(active_depth), .d_in(muxnn4), .d_out(SS4BEG)
  );

  // ------------------------------------------------------------ forwarding
  // Clock and strobes pass straight through to the next tile in the column.
  assign UserCLKo      = UserCLK;
  assign FrameStrobe_O = FrameStrobe;

`ifdef TERM_CFG_READBACK_EN
  assign FrameData_O = FrameStrobe[COMMIT_FRAME]
                     ? {{(FrameBitsPerRow - CFG_W){1'b0}}, active_cfg}
                     : FrameData;
`else
  assign FrameData_O = FrameData;
`endif

endmodule

// File: tb/tb_term_tile_cfg_loopback.sv
module tb_term_tile_cfg_loopback;

  localparam int unsigned W1    = 4;
  localparam int unsigned W2    = 8;
  localparam int unsigned W4    = 16;
  localparam int unsigned MF    = 20;
  localparam int unsigned FB    = 32;
  localparam int unsigned CFG_F = 0;
  localparam int unsigned PAT_F = 1;
  localparam int unsigned COM_F = 2;

  logic          UserCLK = 1'b0;
  logic          RST;
  logic          UserCLKo;
  logic [FB-1:0] FrameData;
  logic [FB-1:0] FrameData_O;
  logic [MF-1:0] FrameStrobe;
  logic [MF-1:0] FrameStrobe_O;
  logic [W1-1:0] N1END;
  logic [W2-1:0] N2MID;
  logic [W2-1:0] N2END;
  logic [W4-1:0] N4END;
  logic [W4-1:0] NN4END;
  logic [W1-1:0] S1BEG;
  logic [W2-1:0] S2BEG;
  logic [W2-1:0] S2BEGb;
  logic [W4-1:0] S4BEG;
  logic [W4-1:0] SS4BEG;
  logic          cfg_active;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [51:0] exp_q [$];
  logic [51:0] got_v;
  logic [51:0] exp_v;

  always #5 UserCLK = ~UserCLK;

  term_tile_cfg_loopback #(
    .W1(W1), .W2(W2), .W4(W4),
    .MaxFramesPerCol(MF), .FrameBitsPerRow(FB),
    .CFG_FRAME(CFG_F), .PAT_FRAME(PAT_F), .COMMIT_FRAME(COM_F),
    .PIPE_MAX(3)
  ) dut (
    .UserCLK(UserCLK), .RST(RST), .UserCLKo(UserCLKo),
    .FrameData(FrameData), .FrameData_O(FrameData_O),
    .FrameStrobe(FrameStrobe), .FrameStrobe_O(FrameStrobe_O),
    .N1END(N1END), .N2MID(N2MID), .N2END(N2END), .N4END(N4END), .NN4END(NN4END),
    .S1BEG(S1BEG), .S2BEG(S2BEG), .S2BEGb(S2BEGb), .S4BEG(S4BEG), .SS4BEG(SS4BEG),
    .cfg_active(cfg_active)
  );

  function automatic logic [51:0] outs();
    return {S1BEG, S2BEG, S2BEGb, S4BEG, SS4BEG};
  endfunction

  function automatic logic [51:0] vec(input logic [3:0] s1, input logic [7:0] s2,
                                      input logic [7:0] s2b, input logic [15:0] s4,
                                      input logic [15:0] ss4);
    return {s1, s2, s2b, s4, ss4};
  endfunction

  task automatic set_n(input logic [3:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [15:0] d, input logic [15:0] e);
    N1END = a; N2MID = b; N2END = c; N4END = d; NN4END = e;
  endtask

  task automatic write_frame(input int unsigned k, input logic [31:0] d);
    FrameStrobe[k] = 1'b1;
    FrameData      = d;
    @(negedge UserCLK);
    FrameStrobe[k] = 1'b0;
  endtask

  task automatic commit_cfg(input logic [31:0] c);
    write_frame(CFG_F, c);
    write_frame(COM_F, 32'h0);
  endtask

  // ---------------------------------------------------------------- reset
  task automatic test_reset();
    RST = 1'b1;
    FrameStrobe = '0;
    FrameData = '0;
    set_n('1, '1, '1, '1, '1);
    for (int i = 0; i < 3; i++) begin
      @(negedge UserCLK);
      exp_q.push_back('0);
      #1;
      got_v = outs(); exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL reset_outs[%0d]: got %h expected %h", i, got_v, exp_v);
      end
      n_cmp++;
      if (cfg_active !== 1'b0) begin
        n_err++; $display("FAIL reset_cfg_active: got %b expected 0", cfg_active);
      end
    end
    n_cmp++;
    if (UserCLKo !== 1'b0) begin
      n_err++; $display("FAIL clk_fwd_low: got %b expected 0", UserCLKo);
    end
    @(posedge UserCLK); #1;
    n_cmp++;
    if (UserCLKo !== 1'b1) begin
      n_err++; $display("FAIL clk_fwd_high: got %b expected 1", UserCLKo);
    end
    @(negedge UserCLK);
    RST = 1'b0;
    FrameStrobe = 20'h5_A5A5;
    FrameData = 32'h1357_9BDF;
    #1;
    n_cmp++;
    if (FrameStrobe_O !== 20'h5_A5A5) begin
      n_err++; $display("FAIL strobe_fwd: got %h expected 5a5a5", FrameStrobe_O);
    end
    FrameStrobe = '0;
    @(negedge UserCLK);
    exp_q.push_back('0);
    #1;
    got_v = outs(); exp_v = exp_q.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL post_reset_outs: got %h expected %h", got_v, exp_v);
    end
  endtask

  // ----------------------------------------------------------- pass/rotate
  task automatic test_pass_rot();
    commit_cfg(32'h0001);
    set_n(4'b0001, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF);
    exp_q.push_back(vec(4'b0001, 8'h00, 8'h00, 16'h0000, 16'h0000));
    #1;
    got_v = outs(); exp_v = exp_q.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL pass_0001: got %h expected %h", got_v, exp_v);
    end
    n_cmp++;
    if (cfg_active !== 1'b1) begin
      n_err++; $display("FAIL cfg_active_set: got %b expected 1", cfg_active);
    end
    N1END = 4'b1010;
    exp_q.push_back(vec(4'b1010, 8'h00, 8'h00, 16'h0000, 16'h0000));
    #1;
    got_v = outs(); exp_v = exp_q.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL pass_1010: got %h expected %h", got_v, exp_v);
    end
    commit_cfg(32'h0002);
    N1END = 4'b0001;
    exp_q.push_back(vec(4'b1000, 8'h00, 8'h00, 16'h0000, 16'h0000));
    #1;
    got_v = outs(); exp_v = exp_q.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL rot_0001: got %h expected %h", got_v, exp_v);
    end
    N1END = 4'b0110;
    exp_q.push_back(vec(4'b0011, 8'h00, 8'h00, 16'h0000, 16'h0000));
    #1;
    got_v = outs(); exp_v = exp_q.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL rot_0110: got %h expected %h", got_v, exp_v);
    end
  endtask

  // -------------------------------------------------------------- pipeline
  task automatic test_pipeline();
    logic [15:0] stim [13];
    stim = '{16'hA5A5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1234, 16'h0F0F,
             16'hFFFF, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0};
    set_n(4'hF, 8'hFF, 8'hFF, 16'h0000, 16'hFFFF);
    commit_cfg(32'h0C40);
    exp_q.delete();
    repeat (3) exp_q.push_back('0);
    for (int i = 0; i < 13; i++) begin
      #1;
      got_v = outs(); exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL pipe_d3[%0d]: got %h expected %h", i, got_v, exp_v);
      end
      N4END = stim[i];
      exp_q.push_back(vec(4'h0, 8'h00, 8'h00, stim[i], 16'h0000));
      @(negedge UserCLK);
    end
    N4END = 16'hBEEF;
    commit_cfg(32'h0440);
    exp_q.delete();
    exp_q.push_back('0);
    for (int i = 0; i < 6; i++) begin
      #1;
      got_v = outs(); exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL pipe_d1[%0d]: got %h expected %h", i, got_v, exp_v);
      end
      N4END = stim[i + 4];
      exp_q.push_back(vec(4'h0, 8'h00, 8'h00, stim[i + 4], 16'h0000));
      @(negedge UserCLK);
    end
    exp_q.delete();
  endtask

  // ------------------------------------------------------ shadow isolation
  task automatic test_shadow();
    set_n(4'b0001, 8'h00, 8'h00, 16'h1234, 16'h0000);
    @(negedge UserCLK);
    FrameStrobe[CFG_F] = 1'b1;
    FrameStrobe[COM_F] = 1'b1;
    FrameData = 32'h0001;
    @(negedge UserCLK);
    FrameStrobe = '0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(vec(4'h0, 8'h00, 8'h00, 16'h1234, 16'h0000));
      #1;
      got_v = outs(); exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL shadow_old[%0d]: got %h expected %h", i, got_v, exp_v);
      end
      @(negedge UserCLK);
    end
    write_frame(COM_F, 32'h0);
    exp_q.push_back(vec(4'b0001, 8'h00, 8'h00, 16'h0000, 16'h0000));
    #1;
    got_v = outs(); exp_v = exp_q.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL shadow_new: got %h expected %h", got_v, exp_v);
    end
  endtask

  // -------------------------------------------------------- constant/hold
  task automatic test_const_hold();
    logic [51:0] p;
    logic [51:0] pn;
    write_frame(PAT_F, 32'h0000_00F3);
    commit_cfg(32'h03FF);
    set_n('1, '1, '1, '1, '1);
    exp_q.push_back(vec(4'h3, 8'h0F, 8'h00, 16'h00F3, 16'h00F3));
    #1;
    got_v = outs(); exp_v = exp_q.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL const_f3: got %h expected %h", got_v, exp_v);
    end
    write_frame(PAT_F, 32'h0000_FFFF);
    exp_q.push_back(vec(4'h3, 8'h0F, 8'h00, 16'h00F3, 16'h00F3));
    #1;
    got_v = outs(); exp_v = exp_q.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL const_latched: got %h expected %h", got_v, exp_v);
    end

    p  = vec(4'h5, 8'h5A, 8'hC3, 16'h1234, 16'h8001);
    pn = ~p;
    set_n(4'h5, 8'h5A, 8'hC3, 16'h1234, 16'h8001);
    commit_cfg(32'h0955);
    repeat (3) @(negedge UserCLK);
    commit_cfg(32'h1955);
    set_n(4'hA, 8'hA5, 8'h3C, 16'hEDCB, 16'h7FFE);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(p);
      #1;
      got_v = outs(); exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL hold_d2[%0d]: got %h expected %h", i, got_v, exp_v);
      end
      @(negedge UserCLK);
    end
    commit_cfg(32'h0955);
    exp_q.delete();
    exp_q.push_back(p);
    exp_q.push_back(p);
    for (int i = 0; i < 4; i++) begin
      #1;
      got_v = outs(); exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL hold_release[%0d]: got %h expected %h", i, got_v, exp_v);
      end
      exp_q.push_back(pn);
      @(negedge UserCLK);
    end
    exp_q.delete();

    commit_cfg(32'h0155);
    set_n(4'h5, 8'h5A, 8'hC3, 16'h1234, 16'h8001);
    @(negedge UserCLK);
    commit_cfg(32'h1155);
    set_n(4'hA, 8'hA5, 8'h3C, 16'hEDCB, 16'h7FFE);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(p);
      #1;
      got_v = outs(); exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL hold_d0[%0d]: got %h expected %h", i, got_v, exp_v);
      end
      @(negedge UserCLK);
    end
  endtask

  // --------------------------------------------- held strobes and readback
  task automatic test_strobe_held();
    set_n(4'b0001, 8'h00, 8'h00, 16'h0000, 16'h0000);
    FrameStrobe[CFG_F] = 1'b1;
    FrameData = 32'h0001;
    @(negedge UserCLK);
    FrameData = 32'h0002;
    repeat (9) @(negedge UserCLK);
    FrameStrobe[CFG_F] = 1'b0;
    write_frame(COM_F, 32'h0);
    exp_q.push_back(vec(4'b0001, 8'h00, 8'h00, 16'h0000, 16'h0000));
    #1;
    got_v = outs(); exp_v = exp_q.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL cfg_held_once: got %h expected %h", got_v, exp_v);
    end

    write_frame(CFG_F, 32'h0002);
    FrameStrobe[COM_F] = 1'b1;
    FrameData = 32'h0000_7000;
    repeat (3) @(negedge UserCLK);
    write_frame(CFG_F, 32'h0001);
    FrameData = 32'hCAFE_F00D;
    repeat (6) @(negedge UserCLK);
    exp_q.push_back(vec(4'b1000, 8'h00, 8'h00, 16'h0000, 16'h0000));
    #1;
    got_v = outs(); exp_v = exp_q.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL commit_held_once: got %h expected %h", got_v, exp_v);
    end
`ifdef TERM_CFG_READBACK_EN
    n_cmp++;
    if (FrameData_O !== 32'h0000_0002) begin
      n_err++; $display("FAIL readback_high: got %h expected 00000002", FrameData_O);
    end
`else
    n_cmp++;
    if (FrameData_O !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL fd_mirror_high: got %h expected cafef00d", FrameData_O);
    end
`endif
    FrameStrobe[COM_F] = 1'b0;
    FrameData = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (FrameData_O !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL fd_mirror_low: got %h expected deadbeef", FrameData_O);
    end
    @(negedge UserCLK);
  endtask

  // ------------------------------------------------------ mid-run reset
  task automatic test_reset_mid();
    set_n('1, '1, '1, '1, '1);
    RST = 1'b1;
    FrameStrobe[CFG_F] = 1'b1;
    FrameStrobe[COM_F] = 1'b1;
    FrameData = 32'h0002;
    @(negedge UserCLK);
    exp_q.push_back('0);
    #1;
    got_v = outs(); exp_v = exp_q.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL midreset_outs: got %h expected %h", got_v, exp_v);
    end
    n_cmp++;
    if (cfg_active !== 1'b0) begin
      n_err++; $display("FAIL midreset_cfg_active: got %b expected 0", cfg_active);
    end
    RST = 1'b0;
    @(negedge UserCLK);
    exp_q.push_back('0);
    #1;
    got_v = outs(); exp_v = exp_q.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL deassert_outs: got %h expected %h", got_v, exp_v);
    end
    n_cmp++;
    if (cfg_active !== 1'b1) begin
      n_err++; $display("FAIL deassert_edge_commit: got %b expected 1", cfg_active);
    end
    FrameStrobe = '0;
    @(negedge UserCLK);
    write_frame(COM_F, 32'h0);
    N1END = 4'b0001;
    exp_q.push_back(vec(4'b1000, 8'h00, 8'h00, 16'h0000, 16'h0000));
    #1;
    got_v = outs(); exp_v = exp_q.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL deassert_edge_capture: got %h expected %h", got_v, exp_v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pass_rot();
    test_pipeline();
    test_shadow();
    test_const_hold();
    test_strobe_held();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
